// File: rtl/sound_pkg.sv
// Shared types for the sound cue sequencer: note codes, cue ids, FSM states.
// Imported by cue_fifo and sound_cue_sequencer.
package sound_pkg;

    localparam logic [3:0] NOTE_SILENT = 4'd0;
    localparam logic [3:0] NOTE_DO     = 4'd1;
    localparam logic [3:0] NOTE_RE     = 4'd2;
    localparam logic [3:0] NOTE_MI     = 4'd3;
    localparam logic [3:0] NOTE_SOL    = 4'd4;

    typedef enum logic [1:0] {
        CUE_WALL,
        CUE_PADDLE,
        CUE_BRICK,
        CUE_LOST
    } cue_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NOTE,
        ST_GAP
    } state_e;

    // Single-note code of each cue; the lost cue falls back to do.
    function automatic logic [3:0] cue_note(input cue_e c);
        logic [3:0] n;
        n = NOTE_SILENT;
        unique case (c)
            CUE_WALL:   n = NOTE_DO;
            CUE_PADDLE: n = NOTE_SOL;
            CUE_BRICK:  n = NOTE_MI;
            CUE_LOST:   n = NOTE_DO;
            default:    n = NOTE_SILENT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cue_fifo.sv
// Synchronous cue queue, power-of-two depth, extra pointer bit for full/empty.
// Ports: clk_i, rst_ni (async low), push_i/data_i, pop_i/data_o, full_o, empty_o.
module cue_fifo
    import sound_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  cue_e data_i,
    input  logic pop_i,
    output cue_e data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cue_e        mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: CUE_WALL};
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/sound_cue_sequencer.sv
// Queues game event strobes and plays them as timed note codes on play_sound.
// Ports: clk50mhz, reset_button (async low), hit_wall/hit_paddle/hit_brick/
// ball_lost strobes in; play_sound[3:0], busy, overflow out (all registered).
// Build option SOUND_SEQ_MELODY_EN: ball_lost plays sol-mi-re-do instead of do.
module sound_cue_sequencer
    import sound_pkg::*;
#(
    parameter logic [31:0] NOTE_TICKS = 32'h2FAF08,
    parameter logic [31:0] GAP_TICKS  = 32'h7A120,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk50mhz,
    input  logic       reset_button,
    input  logic       hit_wall,
    input  logic       hit_paddle,
    input  logic       hit_brick,
    input  logic       ball_lost,
    output logic [3:0] play_sound,
    output logic       busy,
    output logic       overflow
);

    state_e      state_q;
    logic [31:0] cnt_q;
    cue_e        cue_q;
    logic [3:0]  play_q;
    logic        busy_q;
    logic        overflow_q;
`ifdef SOUND_SEQ_MELODY_EN
    logic [1:0]  idx_q;
`endif

    logic        ev_valid;
    cue_e        ev_cue;
    logic        pop;
    cue_e        fifo_cue;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  note_now;

    // Only the highest-priority strobe of a cycle is queued.
    always_comb begin
        ev_valid = hit_wall | hit_paddle | hit_brick | ball_lost;
        ev_cue   = CUE_WALL;
        if (ball_lost)       ev_cue = CUE_LOST;
        else if (hit_brick)  ev_cue = CUE_BRICK;
        else if (hit_paddle) ev_cue = CUE_PADDLE;
        else                 ev_cue = CUE_WALL;
    end

    assign pop = (state_q == ST_IDLE) && !fifo_empty;

    cue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk50mhz),
        .rst_ni  (reset_button),
        .push_i  (ev_valid),
        .data_i  (ev_cue),
        .pop_i   (pop),
        .data_o  (fifo_cue),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SOUND_SEQ_MELODY_EN
    function automatic logic [3:0] melody_note(input logic [1:0] i);
        logic [3:0] n;
        n = NOTE_SILENT;
        unique case (i)
            2'd0:    n = NOTE_SOL;
            2'd1:    n = NOTE_MI;
            2'd2:    n = NOTE_RE;
            2'd3:    n = NOTE_DO;
            default: n = NOTE_SILENT;
        endcase
        return n;
    endfunction

    always_comb begin
        note_now = cue_note(cue_q);
        if (cue_q == CUE_LOST) note_now = melody_note(idx_q);
    end
`else
    always_comb begin
        note_now = cue_note(cue_q);
    end
`endif

    // play_sound trails the FSM state by one edge, so the note appears
    // two edges after the strobe and each note/gap keeps its full length.
    always_ff @(posedge clk50mhz or negedge reset_button) begin
        if (!reset_button) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cue_q      <= CUE_WALL;
            play_q     <= NOTE_SILENT;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef SOUND_SEQ_MELODY_EN
            idx_q      <= '0;
`endif
        end else begin
            busy_q     <= (state_q != ST_IDLE) || !fifo_empty;
            overflow_q <= ev_valid && fifo_full && !pop;
            unique case (state_q)
                ST_IDLE: begin
                    play_q <= NOTE_SILENT;
                    cnt_q  <= '0;
                    if (pop) begin
                        cue_q   <= fifo_cue;
                        state_q <= ST_NOTE;
`ifdef SOUND_SEQ_MELODY_EN
                        idx_q   <= '0;
`endif
                    end
                end
                ST_NOTE: begin
                    play_q <= note_now;
                    if (cnt_q == NOTE_TICKS - 32'd1) begin
                        cnt_q <= '0;
`ifdef SOUND_SEQ_MELODY_EN
                        if (cue_q == CUE_LOST && idx_q != 2'd3) begin
                            idx_q <= idx_q + 2'd1;
                        end else begin
                            state_q <= ST_GAP;
                        end
`else
                        state_q <= ST_GAP;
`endif
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_GAP: begin
                    play_q <= NOTE_SILENT;
                    if (cnt_q == GAP_TICKS - 32'd1) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    play_q  <= NOTE_SILENT;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign play_sound = play_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule
